shift_rows_pipe: RTL
====================

// Module: shift_rows_pipe
// PURPOSE
//  Parametrised ShiftRows/InvShiftRows stage for the AES/Rijndael round datapath.
//  Supports Rijndael block widths Nb = 4/6/8 columns, with a per-block encrypt/decrypt mode bit.
//  Has a STAGES-deep valid/ready pipeline with backpressure.
//  Sits between sub_bytes and mix_columns in the round pipeline; the mode travels with each block.
// PARAMETERS
//  NB      4   state columns; legal 4, 6, 8; any other value is an elaboration error
//  STAGES  1   pipeline register stages; legal 1..4
//  DATA_WIDTH is localparam = 32*NB and is not overridable
// PORTS
//  clk         in   1           clock, rising edge
//  rst         in   1           reset, asynchronous, active-low
//  in_valid    in   1           input block valid
//  in_ready    out  1           stage can accept a block this cycle
//  in_decrypt  in   1           0 = ShiftRows, 1 = InvShiftRows
//  in_data     in   DATA_WIDTH  input state
//  out_valid   out  1           output block valid
//  out_ready   in   1           downstream accepts the block this cycle
//  out_decrypt out  1           mode bit of the output block
//  out_data    out  DATA_WIDTH  permuted state
// BEHAVIOUR
//  Byte layout
//   - State byte k = 4*c + r (column-major).
//   - Byte k occupies bits [DATA_WIDTH-1-8k -: 8], so byte 0 is the MSB byte.
//  Row offsets s(r)
//   - NB = 4 or 6: 0, 1, 2, 3.
//   - NB = 8: 0, 1, 3, 4.
//  Permutation
//   - Encrypt: out[r][c] = in[r][(c + s(r)) mod NB].
//   - Decrypt: out[r][c] = in[r][(c - s(r)) mod NB].
//   - Applied combinationally ahead of stage 0 register; no other logic in the data path.
//  Pipeline
//   - Stage i holds v[i], mode[i], data[i]; stage STAGES-1 drives the out_* ports.
//   - ready[STAGES] = out_ready.
//   - ready[i] = !v[i] | ready[i+1].
//   - in_ready = ready[0]; the path from out_ready to in_ready is combinational.
//   - Stage i loads from its upstream when ready[i] is 1.
//   - Stage 0's upstream is the permuted input and in_valid; stage i's upstream is stage i-1.
//   - When ready[i] is 0, stage i holds all of its fields.
//  Transfers
//   - Input transfer occurs when in_valid & in_ready.
//   - Output transfer occurs when out_valid & out_ready.
//  Latency and throughput
//   - Latency is exactly STAGES cycles from the input transfer edge to out_valid, when no stall occurs.
//   - Throughput is 1 block/cycle while out_ready = 1.
//  Data gating and ordering
//   - data[i] and mode[i] load only when the upstream valid is 1.
//   - Bubbles do not disturb held data.
//   - Blocks leave in arrival order; none is dropped or duplicated.
//  Stalls
//   - If out_valid = 1 and out_ready = 0, out_data and out_decrypt stay stable until the transfer.
//  Reset (rst = 0)
//   - All v[i] = 0, data[i] = 0, mode[i] = 0.
//   - Hence out_valid = 0, out_data = 0, out_decrypt = 0.
//   - in_ready = 1 during reset and on the first cycle after release.
//   - Reset mid-operation discards in-flight blocks without emitting partial output.
//  Invalid input data
//   - in_data and in_decrypt are don't-care when in_valid = 0.
//  Simultaneous events
//   - A full pipeline with out_ready = 1 accepts a new input in the same cycle it emits.
// STRUCTURE
//  Shared package aes_pkg
//   - Function shift_rows_perm(data, decrypt, NB).
//   - Row-offset table function shift_offset(r, NB).
//   - Localparam for byte width (8).
//  Sub-module
//   - One natural sub-module: pipe_stage (single valid/ready register slice).
//   - Instantiated STAGES times in a generate loop.
//  No state machine beyond the per-stage valid bits.
// TESTING
//  T1 FIPS-197 App. B, NB=4, STAGES=1, encrypt
//     - in d42711aee0bf98f1b8b45de51e415230 -> out d4bf5d30e0b452aeb84111f11e2798e5 after 1 cycle.
//  T2 Same, decrypt
//     - in d4bf5d30e0b452aeb84111f11e2798e5 -> out d42711aee0bf98f1b8b45de51e415230, out_decrypt = 1.
//  T3 Counting pattern, NB=4
//     - in 000102030405060708090a0b0c0d0e0f encrypt -> out 00050a0f04090e03080d02070c01060b.
//     - Feeding that result back in decrypt mode -> returns the original pattern.
//  T4 NB=8 counting pattern 00..1f, encrypt
//     - out begins 00050e13 (offsets 0, 1, 3, 4).
//     - Round-trip through encrypt then decrypt equals the input.
//  T5 STAGES=3 backpressure
//     - Stream 10 random blocks with alternating mode; randomly drop out_ready.
//     - Required: the output sequence matches the reference model in order.
//     - Required: out_data is stable while stalled; in_ready = 0 only when all 3 stages are full and out_ready = 0.
//  T6 Reset mid-stream
//     - Assert rst with 2 blocks in flight.
//     - Required: out_valid = 0 and out_data = 0 immediately, with no stale block after release.
//     - Required: the next input emerges after exactly STAGES cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES datapath helpers: byte width, ShiftRows row offsets and the
// ShiftRows/InvShiftRows byte permutation for Rijndael block widths up to 8 columns.
package aes_pkg;

  localparam int BYTE_W = 8;
  localparam int MAX_NB = 8;
  localparam int MAX_W  = 32 * MAX_NB;

  // Row offsets differ only for the 256-bit block, where rows 2 and 3 skip ahead by one.
  function automatic int shift_offset(input int r, input int nb);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  // State sits right-aligned in the container: byte k of an nb-column state is
  // bits [32*nb-1-8k -: 8]; container bits above 32*nb come back as zero.
  function automatic logic [MAX_W-1:0] shift_rows_perm(input logic [MAX_W-1:0] data,
                                                       input logic             decrypt,
                                                       input int               nb);
    logic [MAX_W-1:0] res;
    int               src;
    int               top;
    res = '0;
    top = 32 * nb - 1;
    for (int c = 0; c < MAX_NB; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (c < nb) begin
          if (decrypt) src = (c + nb - shift_offset(r, nb)) % nb;
          else         src = (c + shift_offset(r, nb)) % nb;
          res[top - BYTE_W * (4 * c + r) -: BYTE_W] = data[top - BYTE_W * (4 * src + r) -: BYTE_W];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice of the ShiftRows pipeline. The load enable is
// the stage's ready term, computed by the enclosing pipeline.
module pipe_stage
  import aes_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             up_valid,
  input  logic             up_mode,
  input  logic [WIDTH-1:0] up_data,
  output logic             valid,
  output logic             mode,
  output logic [WIDTH-1:0] data
);

  // Payload only moves when a real block arrives, so bubbles leave it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      mode  <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= up_valid;
      if (up_valid) begin
        mode <= up_mode;
        data <= up_data;
      end
    end
  end

endmodule

// File: rtl/shift_rows_pipe.sv
// ShiftRows/InvShiftRows stage for the AES round datapath: the permutation is
// applied ahead of a STAGES-deep valid/ready pipeline that carries the mode bit.
module shift_rows_pipe
  import aes_pkg::*;
#(
  parameter  int NB         = 4,
  parameter  int STAGES     = 1,
  localparam int DATA_WIDTH = 32 * NB
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_decrypt,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_decrypt,
  output logic [DATA_WIDTH-1:0] out_data
);

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_bad_nb
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("shift_rows_pipe: STAGES must be in 1..4");
  end

  logic [MAX_W-1:0]      in_ext;
  logic [MAX_W-1:0]      perm_ext;
  logic [DATA_WIDTH-1:0] perm_data;

  assign in_ext    = MAX_W'(in_data);
  assign perm_ext  = shift_rows_perm(in_ext, in_decrypt, NB);
  assign perm_data = perm_ext[DATA_WIDTH-1:0];

  if (DATA_WIDTH < MAX_W) begin : g_pad
    logic unused_perm_pad;
    assign unused_perm_pad = ^perm_ext[MAX_W-1:DATA_WIDTH];
  end

  logic [STAGES-1:0]     v;
  logic [STAGES-1:0]     mode;
  logic [DATA_WIDTH-1:0] data [STAGES];
  logic [STAGES-1:0]     ready;

  // Ready ripples back from out_ready; a stage is free if empty or its successor moves.
  always_comb begin
    logic acc;
    acc   = out_ready;
    ready = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      acc      = !v[i] | acc;
      ready[i] = acc;
    end
  end

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    logic                  up_valid;
    logic                  up_mode;
    logic [DATA_WIDTH-1:0] up_data;

    if (i == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_mode  = in_decrypt;
      assign up_data  = perm_data;
    end else begin : g_body
      assign up_valid = v[i-1];
      assign up_mode  = mode[i-1];
      assign up_data  = data[i-1];
    end

    pipe_stage #(
      .WIDTH (DATA_WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (ready[i]),
      .up_valid (up_valid),
      .up_mode  (up_mode),
      .up_data  (up_data),
      .valid    (v[i]),
      .mode     (mode[i]),
      .data     (data[i])
    );
  end

  assign in_ready    = ready[0];
  assign out_valid   = v[STAGES-1];
  assign out_decrypt = mode[STAGES-1];
  assign out_data    = data[STAGES-1];

endmodule
